code_sender: RTL and testbench
==============================

# code_sender

Sequencer that drives the guess-number keypad protocol into the game's input-capture logic. It emits timed, one-hot pulses on four key lines, one pulse per symbol of a stored 4–7-symbol code, then a final enter pulse. It sits between an automatic player or test controller and the key inputs of the game core, replacing manual button presses.

## Interface
- PULSE_CYC, 4, cycles each key/enter pulse is held high (≥1)
- GAP_CYC, 4, low cycles after every pulse (≥1)
- clk  in  1  single system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request to send; sampled only when ready=1
- len  in  3  number of symbols to send; legal 4..7
- code  in  14  symbol k in code[2k+1:2k], k=0 sent first; 0→key1, 1→key2, 2→key3, 3→key4
- abort  in  1  synchronous cancel of a transfer in progress
- ready  out  1  idle, can accept start
- key1..key4  out  1 each  key pulse lines to game core
- enter  out  1  enter pulse line to game core
- done  out  1  one-cycle pulse: full sequence incl. enter sent
- err  out  1  one-cycle pulse: start rejected (len<4)

## Operation
- Reset (async, reset_n=0): state IDLE; ready=1; key1..4, enter, done, err=0; counters cleared.
- FSM states: IDLE, KEY_HI, KEY_LO, ENT_HI, ENT_LO.
- IDLE, start=1, len in 4..7: latch code and len, symbol index←0, go KEY_HI; ready=0.
- IDLE, start=1, len in 0..3: err=1 next cycle, stay IDLE, no key activity.
- KEY_HI: key line selected by current symbol high for PULSE_CYC cycles → KEY_LO.
- KEY_LO: all lines low for GAP_CYC cycles; if index<len-1, index+1 → KEY_HI, else → ENT_HI.
- ENT_HI: enter high PULSE_CYC cycles → ENT_LO; ENT_LO: GAP_CYC low cycles → IDLE with done=1.
- abort=1 in any non-IDLE state: all lines low next cycle, → IDLE, ready=1; no enter, no done.
- start while ready=0 ignored; code/len changes after acceptance ignored.
- Invariant: at most one of key1..4/enter high in any cycle; all outputs registered.

## Timing
- Acceptance edge = cycle 0; T = PULSE_CYC+GAP_CYC.
- Symbol k high during cycles k·T+1 .. k·T+PULSE_CYC.
- enter high during cycles len·T+1 .. len·T+PULSE_CYC.
- done=1 and ready=1 in cycle (len+1)·T+1; new start accepted at that edge (back-to-back, no gap beyond GAP_CYC).
- err pulse in cycle 1 after rejected start; ready stays 1.
- abort sampled at edge n → outputs low and ready=1 from cycle n+1.
- Timer width: clog2(max(PULSE_CYC,GAP_CYC)+1); index 3 bits, never exceeds len-1.

## Structure
- Shared package: FSM state enum, symbol encoding constants (SYM_K1..SYM_K4 = 0..3), MIN_LEN=4, MAX_LEN=7.
- One sub-module: code_sender_timer — loadable down-counter with terminal-count flag, reused for high and gap phases.

## Test plan
- PULSE_CYC=2, GAP_CYC=3; len=5, symbols 0,1,2,3,0 → key1 @1–2, key2 @6–7, key3 @11–12, key4 @16–17, key1 @21–22, enter @26–27, done+ready @31.
- len=3 → err=1 @1 only, no key/enter activity, ready stays 1.
- len=7, all symbols 3 → seven key4 pulses @k·5+1..+2, enter @36–37, done @41; one-hot invariant checked every cycle.
- abort at cycle 12 (key3 high) → key3=0 @13, ready=1 @13, no enter, no done ever.
- reset_n=0 at cycle 7 (mid key2) → all outputs 0 immediately; after release ready=1, new start len=4 completes normally with done @26.
- start held high during transfer → ignored; start in done cycle 31 → accepted, first key @32.

Source files
------------

// File: rtl/code_sender_pkg.sv
// Shared types and constants for the keypad code sequencer.
// Holds the FSM state encoding, symbol-to-key mapping and code length limits.
package code_sender_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        KEY_HI = 3'd1,
        KEY_LO = 3'd2,
        ENT_HI = 3'd3,
        ENT_LO = 3'd4
    } state_e;

    localparam logic [1:0] SYM_K1 = 2'd0;
    localparam logic [1:0] SYM_K2 = 2'd1;
    localparam logic [1:0] SYM_K3 = 2'd2;
    localparam logic [1:0] SYM_K4 = 2'd3;

    localparam int MIN_LEN = 4;
    localparam int MAX_LEN = 7;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);
    localparam int CODE_W  = 2 * MAX_LEN;

    // Key lines ordered {key4, key3, key2, key1}.
    function automatic logic [3:0] sym_onehot(input logic [1:0] sym);
        logic [3:0] oh;
        oh = 4'b0000;
        case (sym)
            SYM_K1:  oh = 4'b0001;
            SYM_K2:  oh = 4'b0010;
            SYM_K3:  oh = 4'b0100;
            SYM_K4:  oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/code_sender_timer.sv
// Loadable down-counter with terminal-count flag.
// Loading value N gives a phase of N+1 cycles; the count parks at zero when idle.
module code_sender_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/code_sender.sv
// Sends a stored 4..7 symbol code as timed one-hot key pulses followed by an enter pulse.
// All outputs are registered from the next-state decode so they change on the decision edge.
//
// state  | meaning
// -------+----------------------------------------------
// IDLE   | ready, waiting for start
// KEY_HI | key line of current symbol held high
// KEY_LO | gap after a key pulse, all lines low
// ENT_HI | enter line held high
// ENT_LO | gap after enter, then done and back to IDLE
module code_sender
    import code_sender_pkg::*;
#(
    parameter int PULSE_CYC = 4,
    parameter int GAP_CYC   = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [CODE_W-1:0] code,
    input  logic              abort,
    output logic              ready,
    output logic              key1,
    output logic              key2,
    output logic              key3,
    output logic              key4,
    output logic              enter,
    output logic              done,
    output logic              err
);

    localparam int TMAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int TW   = $clog2(TMAX + 1);
    localparam logic [TW-1:0] P_LD = TW'(PULSE_CYC - 1);
    localparam logic [TW-1:0] G_LD = TW'(GAP_CYC - 1);

    state_e              state, state_nx;
    logic [LEN_W-1:0]    idx_q, idx_nx;
    logic [LEN_W-1:0]    len_q;
    logic [CODE_W-1:0]   code_q, code_nx, code_sh;
    logic [1:0]          sym_nx;
    logic                accept, done_nx, err_nx;
    logic                tmr_load, tmr_tc;
    logic [TW-1:0]       tmr_val;
    logic [3:0]          key_q;

    code_sender_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    always_comb begin
        state_nx = state;
        idx_nx   = idx_q;
        tmr_load = 1'b0;
        tmr_val  = P_LD;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (len >= LEN_W'(MIN_LEN)) begin
                        accept   = 1'b1;
                        idx_nx   = '0;
                        state_nx = KEY_HI;
                        tmr_load = 1'b1;
                        tmr_val  = P_LD;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            KEY_HI: begin
                if (tmr_tc) begin
                    state_nx = KEY_LO;
                    tmr_load = 1'b1;
                    tmr_val  = G_LD;
                end
            end
            KEY_LO: begin
                if (tmr_tc) begin
                    tmr_load = 1'b1;
                    tmr_val  = P_LD;
                    if (idx_q < len_q - LEN_W'(1)) begin
                        idx_nx   = idx_q + LEN_W'(1);
                        state_nx = KEY_HI;
                    end else begin
                        state_nx = ENT_HI;
                    end
                end
            end
            ENT_HI: begin
                if (tmr_tc) begin
                    state_nx = ENT_LO;
                    tmr_load = 1'b1;
                    tmr_val  = G_LD;
                end
            end
            ENT_LO: begin
                if (tmr_tc) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase

        // Abort wins over every phase decision, including the final done.
        if (abort && (state != IDLE)) begin
            state_nx = IDLE;
            idx_nx   = idx_q;
            tmr_load = 1'b0;
            done_nx  = 1'b0;
        end

        code_nx = accept ? code : code_q;
        code_sh = code_nx >> {idx_nx, 1'b0};
        sym_nx  = code_sh[1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            idx_q  <= '0;
            len_q  <= '0;
            code_q <= '0;
            key_q  <= '0;
            enter  <= 1'b0;
            ready  <= 1'b1;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_nx;
            idx_q  <= idx_nx;
            code_q <= code_nx;
            if (accept) begin
                len_q <= len;
            end
            key_q  <= (state_nx == KEY_HI) ? sym_onehot(sym_nx) : 4'b0000;
            enter  <= (state_nx == ENT_HI);
            ready  <= (state_nx == IDLE);
            done   <= done_nx;
            err    <= err_nx;
        end
    end

    assign key1 = key_q[0];
    assign key2 = key_q[1];
    assign key3 = key_q[2];
    assign key4 = key_q[3];

endmodule

// File: tb/tb_code_sender.sv
// Scoreboard bench for code_sender: stimulus pushes expected per-cycle output vectors,
// a negedge monitor pops and compares them, and every other cycle must be idle.
module tb_code_sender;

    localparam int P = 2;
    localparam int G = 3;
    localparam int T = P + G;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  len = 3'd0;
    logic [13:0] code = 14'd0;
    logic        abort = 1'b0;
    logic        ready, key1, key2, key3, key4, enter, done, err;

    code_sender #(.PULSE_CYC(P), .GAP_CYC(G)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .len     (len),
        .code    (code),
        .abort   (abort),
        .ready   (ready),
        .key1    (key1),
        .key2    (key2),
        .key3    (key3),
        .key4    (key4),
        .enter   (enter),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    // cyc = number of rising edges seen so far; "edge e" outputs are sampled at negedge with cyc==e.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Vector layout: {ready, key4, key3, key2, key1, enter, done, err}
    typedef struct {
        int         e;
        logic [7:0] v;
    } ev_t;

    ev_t q[$];
    int  errors = 0;
    int  checks = 0;
    int  free_edge = 0;

    localparam logic [7:0] IDLE_V = 8'b1000_0000;

    always @(negedge clk) begin
        logic [7:0] v;
        ev_t        x;
        v = {ready, key4, key3, key2, key1, enter, done, err};
        while (q.size() > 0 && q[0].e < cyc) begin
            x = q.pop_front();
            errors++;
            checks++;
            $display("FAIL missed_event edge=%0d expected=%b", x.e, x.v);
        end
        checks++;
        if (q.size() > 0 && q[0].e == cyc) begin
            x = q.pop_front();
            if (v !== x.v) begin
                errors++;
                $display("FAIL output_vector edge=%0d got=%b expected=%b", cyc, v, x.v);
            end
        end else if (v !== IDLE_V) begin
            errors++;
            $display("FAIL idle_vector edge=%0d got=%b expected=%b", cyc, v, IDLE_V);
        end
        checks++;
        if ($countones({key1, key2, key3, key4, enter}) > 1) begin
            errors++;
            $display("FAIL one_hot edge=%0d got=%b expected at most one line high", cyc,
                     {key4, key3, key2, key1, enter});
        end
    end

    // Reference: transfer accepted at edge a lasts (L+1) slots of T cycles; slot k<L carries
    // symbol k, slot L carries enter; pulse occupies the first P cycles of each slot.
    task automatic push_xfer(input int a, input int L, input logic [13:0] c);
        if (L < 4) begin
            q.push_back('{a, 8'b1000_0001});
            free_edge = a + 1;
        end else begin
            for (int e = a; e <= a + (L + 1) * T; e++) begin
                int         r;
                int         slot;
                int         off;
                logic [7:0] v;
                logic [1:0] s;
                r    = e - a;
                slot = r / T;
                off  = r % T;
                v    = 8'b0;
                if (e == a + (L + 1) * T) begin
                    v = 8'b1000_0010;
                end else if (off < P) begin
                    if (slot < L) begin
                        s = c[2 * slot +: 2];
                        v[6:3] = 4'b0001 << s;
                    end else begin
                        v[2] = 1'b1;
                    end
                end
                q.push_back('{e, v});
            end
            free_edge = a + (L + 1) * T + 1;
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_free();
        int guard;
        guard = 0;
        while (cyc + 1 < free_edge && guard < 200) begin
            step(1);
            guard++;
        end
    endtask

    task automatic send(input int L, input logic [13:0] c, output int a);
        wait_free();
        len   = 3'(L);
        code  = c;
        start = 1'b1;
        a     = cyc + 1;
        push_xfer(a, L, c);
        step(1);
        start = 1'b0;
        len   = 3'($urandom_range(0, 7));
        code  = 14'($urandom);
    endtask

    // start held high for a whole transfer while len/code churn; only the values present
    // at the first free edge start the second transfer.
    task automatic send_hold(input int L, input logic [13:0] c, input int L2, input logic [13:0] c2);
        int a;
        int guard;
        wait_free();
        len   = 3'(L);
        code  = c;
        start = 1'b1;
        a     = cyc + 1;
        push_xfer(a, L, c);
        step(1);
        guard = 0;
        while (cyc + 1 < free_edge && guard < 200) begin
            len  = 3'($urandom_range(0, 7));
            code = 14'($urandom);
            step(1);
            guard++;
        end
        len  = 3'(L2);
        code = c2;
        a    = cyc + 1;
        push_xfer(a, L2, c2);
        step(1);
        start = 1'b0;
    endtask

    task automatic abort_at(input int n);
        while (cyc < n - 1) step(1);
        abort = 1'b1;
        while (q.size() > 0 && q[$].e >= n) void'(q.pop_back());
        free_edge = n + 1;
        step(1);
        abort = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached at edge %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        int L;
        int guard;
        logic [13:0] c;

        step(3);
        reset_n   = 1'b1;
        free_edge = cyc + 1;
        step(1);

        // Symbols 0,1,2,3,0 -> code bits 00_11_10_01_00.
        send(5, 14'd228, a);
        send(3, 14'($urandom), a);
        send(7, 14'h3FFF, a);

        send(5, 14'd228, a);
        abort_at(a + 12);

        send(5, 14'd228, a);
        while (cyc < a + 6) step(1);
        #1;
        reset_n = 1'b0;
        q.delete();
        step(2);
        reset_n   = 1'b1;
        free_edge = cyc + 1;
        send(4, 14'($urandom), a);

        send_hold(5, 14'd228, 6, 14'($urandom));

        for (int i = 0; i < 30; i++) begin
            L = $urandom_range(0, 7);
            c = 14'($urandom);
            send(L, c, a);
            if (L >= 4 && ($urandom % 3) == 0)
                abort_at(a + $urandom_range(1, (L + 1) * T));
        end

        guard = 0;
        while (q.size() > 0 && guard < 200) begin
            step(1);
            guard++;
        end
        if (q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain_timeout pending=%0d expected 0", q.size());
        end
        step(3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
